// File: rtl/intp_ctrl_prio_mask.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// intp_ctrl_prio_mask
//
// APB-programmable interrupt controller for NUM_OF_PERIPHERALS lines. Each
// line has a priority field, an enable bit and a capture mode (level or
// rising edge). Pending lines that are enabled and whose priority is strictly
// above the global threshold compete. The highest priority wins, and on a
// tie the lowest index wins. The winner is presented to the CPU and held
// until the CPU acknowledges it.
//
// Register map (word address):
//   0..N-1 : PRIO[i]    RW, low PRIO_WIDTH bits
//   N      : ENABLE     RW, bit i per line
//   N+1    : MODE       RW, 1 = edge capture, 0 = level capture
//   N+2    : PENDING    R = pending vector, W = write-1-to-clear (edge lines)
//   N+3    : THRESHOLD  RW, low PRIO_WIDTH bits
//   >= N+4 : unmapped, slave error, reads 0, writes dropped
//
// Ports:
//   pclk_i, prst_i       clock (rising edge), asynchronous active-low reset
//   paddr_i, pwrite_i,
//   pwdata_i, penable_i  APB request (one wait state per transfer)
//   prdata_o, pready_o,
//   perror_o             APB response (registered)
//   intp_active_i        raw peripheral interrupt lines (pclk_i domain)
//   intp_valid_o         an interrupt is presented
//   intp_to_service_o    index of the presented interrupt
//   intp_serviced_i      CPU acknowledge of the presented interrupt
// ---------------------------------------------------------------------------
module intp_ctrl_prio_mask #(
    parameter int  NUM_OF_PERIPHERALS = 16,
    parameter int  PRIO_WIDTH         = 4,
    parameter int  ADDR_WIDTH         = 6,
    parameter int  DATA_WIDTH         = 32,
    localparam int ID_WIDTH           = $clog2(NUM_OF_PERIPHERALS)
) (
    input  logic                          pclk_i,
    input  logic                          prst_i,
    input  logic [ADDR_WIDTH-1:0]         paddr_i,
    input  logic                          pwrite_i,
    input  logic [DATA_WIDTH-1:0]         pwdata_i,
    input  logic                          penable_i,
    output logic [DATA_WIDTH-1:0]         prdata_o,
    output logic                          pready_o,
    output logic                          perror_o,
    input  logic [NUM_OF_PERIPHERALS-1:0] intp_active_i,
    output logic                          intp_valid_o,
    output logic [ID_WIDTH-1:0]           intp_to_service_o,
    input  logic                          intp_serviced_i
);

    localparam int N = NUM_OF_PERIPHERALS;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ENABLE    = ADDR_WIDTH'(N);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MODE      = ADDR_WIDTH'(N + 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_PENDING   = ADDR_WIDTH'(N + 2);
    localparam logic [ADDR_WIDTH-1:0] ADDR_THRESHOLD = ADDR_WIDTH'(N + 3);
    // One extra bit so the limit still fits when N+4 equals 2^ADDR_WIDTH.
    localparam logic [ADDR_WIDTH:0]   ADDR_LIMIT     = (ADDR_WIDTH + 1)'(N + 4);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    // Configuration registers
    logic [PRIO_WIDTH-1:0] prio_q [N];
    logic [PRIO_WIDTH-1:0] prio_d [N];
    logic [N-1:0]          enable_q, enable_d;
    logic [N-1:0]          mode_q, mode_d;
    logic [PRIO_WIDTH-1:0] threshold_q, threshold_d;

    // Capture state
    logic [N-1:0]          pending_q, pending_d;
    logic [N-1:0]          active_prev_q, active_prev_d;

    // Presentation FSM and outputs
    state_t                state_q, state_d;
    logic                  valid_q, valid_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic                  pready_q, pready_d;
    logic                  perror_q, perror_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;

    // Combinational helpers
    logic                  access_s;
    logic                  wr_commit_s;
    logic                  addr_bad_s;
    logic                  svc_done_s;
    logic [N-1:0]          rise_s;
    logic [N-1:0]          w1c_s;
    logic [N-1:0]          svc_clr_s;
    logic [N-1:0]          elig_s;
    logic                  take_s;
    logic                  any_elig_s;
    logic [PRIO_WIDTH-1:0] best_prio_s;
    logic [ID_WIDTH-1:0]   best_id_s;
    logic [PRIO_WIDTH-1:0] prio_rd_s;
    logic [DATA_WIDTH-1:0] rd_data_s;
    logic                  unused_pwdata_s;

    // First access cycle: the response is registered for the next cycle.
    assign access_s    = penable_i & ~pready_q;
    // The transfer completes (and a write commits) when penable and pready meet.
    assign wr_commit_s = penable_i & pready_q & pwrite_i;
    assign addr_bad_s  = ({1'b0, paddr_i} >= ADDR_LIMIT);
    assign svc_done_s  = (state_q == ST_GRANT) & intp_serviced_i;
    // Upper write-data bits above the register widths are intentionally ignored.
    assign unused_pwdata_s = ^pwdata_i;

    // Next value of the configuration registers from committing APB writes.
    always_comb begin
        prio_d      = prio_q;
        enable_d    = enable_q;
        mode_d      = mode_q;
        threshold_d = threshold_q;
        for (int i = 0; i < N; i++) begin
            if (wr_commit_s && (paddr_i == ADDR_WIDTH'(i))) begin
                prio_d[i] = pwdata_i[PRIO_WIDTH-1:0];
            end else begin
                prio_d[i] = prio_q[i];
            end
        end
        if (wr_commit_s && (paddr_i == ADDR_ENABLE)) begin
            enable_d = pwdata_i[N-1:0];
        end else begin
            enable_d = enable_q;
        end
        if (wr_commit_s && (paddr_i == ADDR_MODE)) begin
            mode_d = pwdata_i[N-1:0];
        end else begin
            mode_d = mode_q;
        end
        if (wr_commit_s && (paddr_i == ADDR_THRESHOLD)) begin
            threshold_d = pwdata_i[PRIO_WIDTH-1:0];
        end else begin
            threshold_d = threshold_q;
        end
    end

    // Per-line pending capture: level lines follow the input, edge lines latch.
    always_comb begin
        rise_s        = intp_active_i & ~active_prev_q;
        active_prev_d = intp_active_i;
        svc_clr_s     = '0;
        pending_d     = '0;
        if (wr_commit_s && (paddr_i == ADDR_PENDING)) begin
            w1c_s = pwdata_i[N-1:0];
        end else begin
            w1c_s = '0;
        end
        for (int i = 0; i < N; i++) begin
            svc_clr_s[i] = svc_done_s & (id_q == ID_WIDTH'(i));
            if (mode_q[i]) begin
                // A new rising edge wins over a clear in the same cycle.
                pending_d[i] = rise_s[i] | (pending_q[i] & ~svc_clr_s[i] & ~w1c_s[i]);
            end else begin
                pending_d[i] = intp_active_i[i];
            end
        end
    end

    // Eligibility and winner search: highest priority, lowest index on a tie.
    always_comb begin
        elig_s      = '0;
        take_s      = 1'b0;
        any_elig_s  = 1'b0;
        best_prio_s = '0;
        best_id_s   = '0;
        for (int i = 0; i < N; i++) begin
            // Strict compare also keeps priority 0 out, since threshold >= 0.
            elig_s[i]   = pending_q[i] & enable_q[i] & (prio_q[i] > threshold_q);
            take_s      = elig_s[i] & (~any_elig_s | (prio_q[i] > best_prio_s));
            best_prio_s = take_s ? prio_q[i] : best_prio_s;
            best_id_s   = take_s ? ID_WIDTH'(i) : best_id_s;
            any_elig_s  = any_elig_s | elig_s[i];
        end
    end

    // Presentation FSM: grant is held until serviced, then one quiet cycle.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        case (state_q)
            ST_IDLE: begin
                if (any_elig_s) begin
                    state_d = ST_GRANT;
                    id_d    = best_id_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (intp_serviced_i) begin
                    state_d = ST_CLEAR;
                end else begin
                    state_d = ST_GRANT;
                end
            end
            // Gives level sources a cycle to drop before re-arbitration.
            ST_CLEAR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        valid_d = (state_d == ST_GRANT);
    end

    // Read mux and registered APB response.
    always_comb begin
        prio_rd_s = '0;
        rd_data_s = '0;
        for (int i = 0; i < N; i++) begin
            prio_rd_s = prio_rd_s |
                        ((paddr_i == ADDR_WIDTH'(i)) ? prio_q[i] : {PRIO_WIDTH{1'b0}});
        end
        case (paddr_i)
            ADDR_ENABLE:    rd_data_s[N-1:0]          = enable_q;
            ADDR_MODE:      rd_data_s[N-1:0]          = mode_q;
            ADDR_PENDING:   rd_data_s[N-1:0]          = pending_q;
            ADDR_THRESHOLD: rd_data_s[PRIO_WIDTH-1:0] = threshold_q;
            // PRIO range, or zero for unmapped addresses (prio_rd_s is 0 there).
            default:        rd_data_s[PRIO_WIDTH-1:0] = prio_rd_s;
        endcase
        pready_d = access_s;
        perror_d = access_s & addr_bad_s;
        if (access_s && !pwrite_i) begin
            prdata_d = rd_data_s;
        end else begin
            prdata_d = '0;
        end
    end

    // Configuration register state.
    always_ff @(posedge pclk_i or negedge prst_i) begin
        if (!prst_i) begin
            for (int i = 0; i < N; i++) begin
                prio_q[i] <= '0;
            end
            enable_q    <= '0;
            mode_q      <= '0;
            threshold_q <= '0;
        end else begin
            prio_q      <= prio_d;
            enable_q    <= enable_d;
            mode_q      <= mode_d;
            threshold_q <= threshold_d;
        end
    end

    // Pending vector and previous-input sample for edge detection.
    always_ff @(posedge pclk_i or negedge prst_i) begin
        if (!prst_i) begin
            pending_q     <= '0;
            active_prev_q <= '0;
        end else begin
            pending_q     <= pending_d;
            active_prev_q <= active_prev_d;
        end
    end

    // FSM state and registered interrupt / APB outputs.
    always_ff @(posedge pclk_i or negedge prst_i) begin
        if (!prst_i) begin
            state_q  <= ST_IDLE;
            valid_q  <= 1'b0;
            id_q     <= '0;
            pready_q <= 1'b0;
            perror_q <= 1'b0;
            prdata_q <= '0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            id_q     <= id_d;
            pready_q <= pready_d;
            perror_q <= perror_d;
            prdata_q <= prdata_d;
        end
    end

    assign prdata_o          = prdata_q;
    assign pready_o          = pready_q;
    assign perror_o          = perror_q;
    assign intp_valid_o      = valid_q;
    assign intp_to_service_o = id_q;

endmodule

// File: tb/tb_intp_ctrl_prio_mask.sv
`timescale 1ns/1ps
module tb_intp_ctrl_prio_mask;

    localparam int N  = 16;
    localparam int PW = 4;
    localparam int AW = 6;
    localparam int DW = 32;
    localparam int IW = $clog2(N);

    logic          pclk = 1'b0;
    logic          prst_i;
    logic [AW-1:0] paddr_i;
    logic          pwrite_i;
    logic [DW-1:0] pwdata_i;
    logic          penable_i;
    logic [DW-1:0] prdata_o;
    logic          pready_o;
    logic          perror_o;
    logic [N-1:0]  intp_active_i;
    logic          intp_valid_o;
    logic [IW-1:0] intp_to_service_o;
    logic          intp_serviced_i;

    int checks = 0;
    int errors = 0;
    bit rand_on = 1'b0;

    intp_ctrl_prio_mask #(
        .NUM_OF_PERIPHERALS(N),
        .PRIO_WIDTH(PW),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .pclk_i(pclk),
        .prst_i(prst_i),
        .paddr_i(paddr_i),
        .pwrite_i(pwrite_i),
        .pwdata_i(pwdata_i),
        .penable_i(penable_i),
        .prdata_o(prdata_o),
        .pready_o(pready_o),
        .perror_o(perror_o),
        .intp_active_i(intp_active_i),
        .intp_valid_o(intp_valid_o),
        .intp_to_service_o(intp_to_service_o),
        .intp_serviced_i(intp_serviced_i)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    int           m_prio [N];
    logic [N-1:0] m_en, m_mode, m_pend, m_prev;
    int           m_thr;
    bit           m_valid;
    int           m_id;
    int           m_hold;   // edges after a service during which no new grant may start
    bit           m_pready, m_perr;
    logic [31:0]  m_prdata;

    function automatic logic [31:0] m_read(input int a);
        if (a < N)      return 32'(m_prio[a]);
        if (a == N)     return 32'(m_en);
        if (a == N + 1) return 32'(m_mode);
        if (a == N + 2) return 32'(m_pend);
        if (a == N + 3) return 32'(m_thr);
        return 32'd0;
    endfunction

    function automatic int m_winner();
        int best = -1;
        for (int i = 0; i < N; i++) begin
            if (m_pend[i] && m_en[i] && (m_prio[i] > m_thr) &&
                (best < 0 || m_prio[i] > m_prio[best])) best = i;
        end
        return best;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_prio[i] = 0;
        m_en = '0; m_mode = '0; m_pend = '0; m_prev = '0; m_thr = 0;
        m_valid = 1'b0; m_id = 0; m_hold = 0;
        m_pready = 1'b0; m_perr = 1'b0; m_prdata = 32'd0;
    endtask

    task automatic model_step();
        int a, w;
        bit access, commit, svc, rose, cleared;
        logic [N-1:0] act, np;
        logic [31:0] rd;
        a      = int'(paddr_i);
        act    = intp_active_i;
        access = penable_i && !m_pready;
        commit = penable_i && m_pready;
        svc    = m_valid && intp_serviced_i;
        w      = m_winner();
        for (int i = 0; i < N; i++) begin
            rose    = act[i] && !m_prev[i];
            cleared = (svc && m_id == i) || (commit && pwrite_i && a == N + 2 && pwdata_i[i]);
            if (m_mode[i]) np[i] = rose ? 1'b1 : (cleared ? 1'b0 : m_pend[i]);
            else           np[i] = act[i];
        end
        rd = (access && !pwrite_i) ? m_read(a) : 32'd0;
        if (commit && pwrite_i) begin
            if (a < N)           m_prio[a] = int'(pwdata_i[PW-1:0]);
            else if (a == N)     m_en      = pwdata_i[N-1:0];
            else if (a == N + 1) m_mode    = pwdata_i[N-1:0];
            else if (a == N + 3) m_thr     = int'(pwdata_i[PW-1:0]);
        end
        if (m_valid) begin
            if (intp_serviced_i) begin
                m_valid = 1'b0;
                m_hold  = 1;
            end
        end else if (m_hold > 0) begin
            m_hold--;
        end else if (w >= 0) begin
            m_valid = 1'b1;
            m_id    = w;
        end
        m_pend   = np;
        m_prev   = act;
        m_pready = access;
        m_perr   = access && (a >= N + 4);
        m_prdata = rd;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge pclk or negedge prst_i);
            if (!prst_i) model_reset();
            else model_step();
        end
    end

    // Cycle-by-cycle comparison of every output against the model.
    initial begin
        forever begin
            @(negedge pclk);
            check("cmp_valid",  32'(intp_valid_o), 32'(m_valid));
            check("cmp_index",  32'(intp_to_service_o), 32'(m_id));
            check("cmp_pready", 32'(pready_o), 32'(m_pready));
            check("cmp_perror", 32'(perror_o), 32'(m_perr));
            check("cmp_prdata", prdata_o, m_prdata);
        end
    end

    // Random interrupt-line and acknowledge driver.
    initial begin
        forever begin
            @(negedge pclk);
            if (rand_on) begin
                if ($urandom_range(0, 3) == 0) intp_active_i = 16'($urandom);
                intp_serviced_i = ($urandom_range(0, 2) == 0);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic apb(input bit wr, input int addr, input logic [31:0] data,
                       input logic [N-1:0] pulse, output logic [31:0] rdata, output logic err);
        paddr_i   = addr[AW-1:0];
        pwrite_i  = wr;
        pwdata_i  = data;
        penable_i = 1'b0;
        @(negedge pclk);
        penable_i = 1'b1;
        @(negedge pclk);
        check("apb_pready_hi", 32'(pready_o), 32'd1);
        rdata = prdata_o;
        err   = perror_o;
        intp_active_i = intp_active_i | pulse;
        @(negedge pclk);
        penable_i = 1'b0;
        intp_active_i = intp_active_i & ~pulse;
        check("apb_pready_lo", 32'(pready_o), 32'd0);
    endtask

    task automatic wr(input int addr, input logic [31:0] d);
        logic [31:0] r;
        logic e;
        apb(1'b1, addr, d, '0, r, e);
    endtask

    task automatic rd(input int addr, output logic [31:0] d, output logic e);
        apb(1'b0, addr, 32'd0, '0, d, e);
    endtask

    task automatic wait_valid(input int max, input string name);
        int n = 0;
        while (!intp_valid_o && n < max) begin
            @(negedge pclk);
            n++;
        end
        check(name, 32'(intp_valid_o), 32'd1);
    endtask

    task automatic service(input logic [N-1:0] drop);
        intp_serviced_i = 1'b1;
        intp_active_i   = intp_active_i & ~drop;
        @(negedge pclk);
        intp_serviced_i = 1'b0;
    endtask

    task automatic idle_check(input int n, input string name);
        repeat (n) begin
            @(negedge pclk);
            check(name, 32'(intp_valid_o), 32'd0);
        end
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [31:0] r;
        logic e;
        int low;
        int addr;
        logic [31:0] data;

        prst_i = 1'b0; paddr_i = '0; pwrite_i = 1'b0; pwdata_i = '0; penable_i = 1'b0;
        intp_active_i = '0; intp_serviced_i = 1'b0;
        repeat (3) @(negedge pclk);
        check("rst_prdata", prdata_o, 32'd0);
        check("rst_pready", 32'(pready_o), 32'd0);
        check("rst_perror", 32'(perror_o), 32'd0);
        check("rst_valid",  32'(intp_valid_o), 32'd0);
        check("rst_index",  32'(intp_to_service_o), 32'd0);
        prst_i = 1'b1;
        @(negedge pclk);

        // APB basic access and unmapped address
        wr(5, 32'h0000_000A);
        rd(5, r, e);
        check("prio5_read", r, 32'h0000_000A);
        check("prio5_err", 32'(e), 32'd0);
        wr(N + 4, 32'hFFFF_FFFF);
        rd(N + 4, r, e);
        check("bad_addr_data", r, 32'd0);
        check("bad_addr_err", 32'(e), 32'd1);
        rd(63, r, e);
        check("addr63_err", 32'(e), 32'd1);
        rd(N, r, e);
        check("enable_untouched", r, 32'd0);

        // Priority and tie-break
        wr(2, 32'd7); wr(9, 32'd7); wr(4, 32'd3); wr(N, 32'h0000_FFFF);
        intp_active_i = 16'h0214;
        wait_valid(10, "tie_valid_a");
        check("tie_first", 32'(intp_to_service_o), 32'd2);
        service(16'h0004);
        wait_valid(10, "tie_valid_b");
        check("tie_second", 32'(intp_to_service_o), 32'd9);
        service(16'h0200);
        wait_valid(10, "tie_valid_c");
        check("tie_third", 32'(intp_to_service_o), 32'd4);
        service(16'h0010);
        idle_check(4, "tie_done_idle");

        // Threshold and mask
        wr(N + 3, 32'd5); wr(1, 32'd5); wr(6, 32'd6); wr(N, 32'h0000_FFBF);
        intp_active_i = 16'h0042;
        idle_check(10, "masked_idle");
        wr(N, 32'h0000_FFFF);
        check("unmask_not_yet", 32'(intp_valid_o), 32'd0);
        @(negedge pclk);
        check("unmask_valid", 32'(intp_valid_o), 32'd1);
        check("unmask_index", 32'(intp_to_service_o), 32'd6);
        service(16'h0040);
        idle_check(8, "thr_line1_never");
        intp_active_i = '0;

        // Edge mode
        wr(3, 32'd8); wr(N + 1, 32'h0000_0008);
        intp_active_i[3] = 1'b1;
        @(negedge pclk);
        intp_active_i[3] = 1'b0;
        rd(N + 2, r, e);
        check("edge_pending", r, 32'h0000_0008);
        check("edge_valid", 32'(intp_valid_o), 32'd1);
        check("edge_index", 32'(intp_to_service_o), 32'd3);
        service('0);
        rd(N + 2, r, e);
        check("edge_cleared", r, 32'd0);
        apb(1'b1, N + 2, 32'h0000_0008, 16'h0008, r, e);
        rd(N + 2, r, e);
        check("w1c_set_wins", r, 32'h0000_0008);
        wr(N + 2, 32'h0000_0008);
        rd(N + 2, r, e);
        check("w1c_clears", r, 32'd0);
        check("w1c_no_preempt", 32'(intp_valid_o), 32'd1);
        service('0);
        wr(N + 1, 32'd0);

        // Level mode: held line is re-granted after exactly two low cycles
        wr(0, 32'd9);
        intp_active_i[0] = 1'b1;
        wait_valid(10, "level_valid");
        check("level_index", 32'(intp_to_service_o), 32'd0);
        service('0);
        low = 0;
        while (!intp_valid_o && low < 10) begin
            low++;
            @(negedge pclk);
        end
        check("level_gap", 32'(low), 32'd2);
        check("level_regrant", 32'(intp_to_service_o), 32'd0);
        intp_active_i[0] = 1'b0;
        repeat (5) begin
            @(negedge pclk);
            check("level_hold", 32'(intp_valid_o), 32'd1);
        end
        service('0);
        idle_check(5, "level_dropped_idle");

        // Asynchronous reset mid-grant
        intp_active_i[0] = 1'b1;
        wait_valid(10, "rst_mid_valid");
        #2;
        prst_i = 1'b0;
        #1;
        check("arst_valid",  32'(intp_valid_o), 32'd0);
        check("arst_index",  32'(intp_to_service_o), 32'd0);
        check("arst_pready", 32'(pready_o), 32'd0);
        check("arst_perror", 32'(perror_o), 32'd0);
        check("arst_prdata", prdata_o, 32'd0);
        intp_active_i = '0;
        @(negedge pclk);
        prst_i = 1'b1;
        @(negedge pclk);
        rd(3, r, e);     check("rb_prio3", r, 32'd0);
        rd(N, r, e);     check("rb_enable", r, 32'd0);
        rd(N + 1, r, e); check("rb_mode", r, 32'd0);
        rd(N + 3, r, e); check("rb_threshold", r, 32'd0);

        // Randomised traffic against the model
        rand_on = 1'b1;
        repeat (300) begin
            addr = $urandom_range(0, N + 5);
            if ($urandom_range(0, 15) == 0) addr = 63;
            data = $urandom;
            if (addr == N + 3) data = 32'($urandom_range(0, 4));
            if (addr == N && $urandom_range(0, 1) == 1) data = 32'h0000_FFFF;
            apb(1'($urandom_range(0, 1)), addr, data, '0, r, e);
        end
        rand_on = 1'b0;
        intp_serviced_i = 1'b0;
        intp_active_i = '0;
        repeat (10) @(negedge pclk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/intp_ctrl_prio_mask.md
# intp_ctrl_prio_mask

Parametrised APB-programmable interrupt controller for N peripheral interrupt lines, the successor to the fixed 16-line priority controller. It adds a per-line enable mask, per-line edge/level capture mode, a global priority threshold and a readable pending register, and presents one winning interrupt at a time to the CPU with a valid/serviced handshake. It sits between the peripheral interrupt lines and the CPU's interrupt input, on the APB slave bus.

## Interface
- NUM_OF_PERIPHERALS, 16, number of interrupt lines N (2..32)
- PRIO_WIDTH, 4, width of each priority field
- ADDR_WIDTH, 6, APB word-address width; 2^ADDR_WIDTH ≥ N+4
- DATA_WIDTH, 32, APB data width; ≥ N and ≥ PRIO_WIDTH
- ID_WIDTH (localparam) = $clog2(NUM_OF_PERIPHERALS)

- pclk_i  in  1  clock, all logic on rising edge
- prst_i  in  1  asynchronous, active-low reset
- paddr_i  in  ADDR_WIDTH  APB word address
- pwrite_i  in  1  1=write, 0=read
- pwdata_i  in  DATA_WIDTH  write data
- penable_i  in  1  APB access phase
- prdata_o  out  DATA_WIDTH  read data, valid with pready_o
- pready_o  out  1  transfer complete
- perror_o  out  1  slave error, valid with pready_o
- intp_active_i  in  N  raw peripheral interrupt lines (synchronous to pclk_i)
- intp_valid_o  out  1  an interrupt is presented
- intp_to_service_o  out  ID_WIDTH  index of presented interrupt
- intp_serviced_i  in  1  CPU acknowledges the presented interrupt

## Operation
- Register map (word address): 0..N-1 PRIO[i] RW, low PRIO_WIDTH bits; N ENABLE RW (bit i per line); N+1 MODE RW (1=edge, 0=level); N+2 PENDING, read returns pending vector, write is W1C on edge-mode bits only; N+3 THRESHOLD RW, low PRIO_WIDTH bits. Unused upper bits read 0, writes ignored.
- Address ≥ N+4: write discarded, read returns 0, perror_o=1 with pready_o.
- All registers reset to 0 (all lines disabled, level mode, threshold 0).
- Pending capture, per line, every cycle: level mode pending[i] = intp_active_i[i] registered; edge mode pending[i] set on 0→1 of intp_active_i[i] (previous-value register), cleared by service of line i or W1C. Set beats clear in the same cycle.
- Eligible[i] = pending[i] & ENABLE[i] & (PRIO[i] > THRESHOLD). Winner = highest PRIO; tie → lowest index. Priority 0 never eligible.
- FSM: IDLE → GRANT when any eligible (winner latched into intp_to_service_o). GRANT: intp_valid_o=1, index held fixed (no preemption, even if the line is disabled or drops); on intp_serviced_i=1 clear pending of that line if edge mode, → CLEAR. CLEAR: one cycle, valid=0, lets level sources drop → IDLE.
- intp_serviced_i outside GRANT is ignored.
- Register writes take effect on the completing edge; arbitration uses register values from the previous cycle.
- Reset mid-operation: FSM to IDLE, all outputs to reset values immediately (asynchronous).

## Timing
- Reset values: prdata_o=0, pready_o=0, perror_o=0, intp_valid_o=0, intp_to_service_o=0.
- APB: setup cycle penable_i=0; access begins when penable_i=1; pready_o registered, high in the cycle after penable_i rises, for exactly one cycle; transfer completes when penable_i & pready_o; one wait state per transfer. Write commits at that edge; prdata_o/perror_o valid while pready_o=1, 0 otherwise.
- Interrupt latency: intp_active_i high before edge E0 → pending at E0 → GRANT at E1; intp_valid_o high 2 cycles after the line is sampled.
- intp_serviced_i sampled high at edge S → intp_valid_o low after S; CLEAR at S..S+1; earliest next intp_valid_o after edge S+2.

## Test plan
- Reset: prst_i=0 asynchronously mid-GRANT → all outputs 0 immediately; readback of PRIO[3], ENABLE, MODE, THRESHOLD = 0.
- APB: write PRIO[5]=0xA, read back 0xA with pready_o one cycle after penable_i; access address N+4 → perror_o=1, prdata_o=0, no state change.
- Priority/tie: ENABLE=0xFFFF, PRIO[2]=7, PRIO[9]=7, PRIO[4]=3, lines 2,4,9 active → grants 2, then 9, then 4 after each service.
- Threshold/mask: THRESHOLD=5, PRIO[1]=5, PRIO[6]=6, both active, ENABLE bit 6 clear → no valid; set ENABLE bit 6 → index 6 presented 2 cycles later; line 1 never.
- Edge mode: MODE bit 3=1, pulse line 3 for one cycle → PENDING reads 0x0008, index 3 granted, cleared on service; W1C 0x0008 on re-pulse in same cycle → bit stays set.
- Level mode: line 0 held high through service → re-granted after CLEAR (valid low exactly 2 cycles); line dropped before service → valid stays high until serviced.
